// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sequencer that shares one bitwise logic
// unit (AND/OR/XOR/NOT) among N_REQ requesters. A granted request is latched
// in IDLE, evaluated in EXEC, and its result held in RESP until acknowledged.
module logic_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         REQ,
    input  logic [2*N_REQ-1:0]       OP,
    input  logic [WIDTH*N_REQ-1:0]   X_IN,
    input  logic [WIDTH*N_REQ-1:0]   Y_IN,
    output logic [N_REQ-1:0]         GNT,
    output logic [WIDTH-1:0]         OUT,
    output logic [2:0]               OUT_ID,
    output logic                     OUT_VALID,
    input  logic                     OUT_ACK,
    output logic                     BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]       ptr;
    logic [2:0]       winner;
    logic             found;
    logic [1:0]       lat_op;
    logic [WIDTH-1:0] lat_x;
    logic [WIDTH-1:0] lat_y;
    logic [2:0]       lat_id;

    // Shared bitwise unit; result is exactly WIDTH bits, Y unused for NOT.
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        case (op)
            2'b00:   logic_op = x & y;
            2'b01:   logic_op = x | y;
            2'b10:   logic_op = x ^ y;
            default: logic_op = ~x;
        endcase
    endfunction

    // Round-robin search starting at ptr; first requesting index wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && REQ[idx]) begin
                found  = 1'b1;
                winner = 3'(idx);
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: REQ is only looked at in IDLE, ACK only in RESP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (OUT_ACK) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, grant, pointer and registered result outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr       <= '0;
            GNT       <= '0;
            OUT       <= '0;
            OUT_ID    <= '0;
            OUT_VALID <= 1'b0;
            lat_op    <= '0;
            lat_x     <= '0;
            lat_y     <= '0;
            lat_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        lat_op <= OP[2*int'(winner) +: 2];
                        lat_x  <= X_IN[int'(winner)*WIDTH +: WIDTH];
                        lat_y  <= Y_IN[int'(winner)*WIDTH +: WIDTH];
                        lat_id <= winner;
                        GNT    <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                        ptr    <= 3'((int'(winner) + 1) % N_REQ);
                    end
                end
                EXEC: begin
                    OUT       <= logic_op(lat_op, lat_x, lat_y);
                    OUT_ID    <= lat_id;
                    OUT_VALID <= 1'b1;
                    GNT       <= '0;
                end
                RESP: begin
                    if (OUT_ACK) OUT_VALID <= 1'b0;
                end
                default: begin
                    GNT       <= '0;
                    OUT_VALID <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (WIDTH=8, N_REQ=4).
module tb_logic_unit_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [7:0]  OP;
    logic [31:0] X_IN;
    logic [31:0] Y_IN;
    logic [3:0]  GNT;
    logic [7:0]  OUT;
    logic [2:0]  OUT_ID;
    logic        OUT_VALID;
    logic        OUT_ACK;
    logic        BUSY;

    int tests = 0;
    int fails = 0;

    logic_unit_arbiter #(.WIDTH(8), .N_REQ(4)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .X_IN(X_IN), .Y_IN(Y_IN),
        .GNT(GNT), .OUT(OUT), .OUT_ID(OUT_ID), .OUT_VALID(OUT_VALID),
        .OUT_ACK(OUT_ACK), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        tests++;
        if (GNT !== 4'b0000 || OUT !== 8'h00 || OUT_ID !== 3'd0 || OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
            $display("FAIL reset_state: got gnt=%b out=%h id=%0d vld=%b busy=%b want all zero", GNT, OUT, OUT_ID, OUT_VALID, BUSY);
            fails++;
        end
        RST = 1'b0;
        tick();
        tests++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
            $display("FAIL reset_idle: got gnt=%b busy=%b want 0000/0", GNT, BUSY);
            fails++;
        end
    endtask

    task automatic test_single();
        OP   = 8'b00_00_00_00;
        X_IN = 32'h00_F0_00_00;
        Y_IN = 32'h00_3C_00_00;
        REQ  = 4'b0100;
        tick();
        REQ = 4'b0000;
        tests++;
        if (GNT !== 4'b0100 || BUSY !== 1'b1 || OUT_VALID !== 1'b0) begin
            $display("FAIL single_gnt: got gnt=%b busy=%b vld=%b want 0100/1/0", GNT, BUSY, OUT_VALID);
            fails++;
        end
        tick();
        tests++;
        if (OUT !== 8'h30 || OUT_ID !== 3'd2 || OUT_VALID !== 1'b1 || GNT !== 4'b0000) begin
            $display("FAIL single_result: got out=%h id=%0d vld=%b gnt=%b want 30/2/1/0000", OUT, OUT_ID, OUT_VALID, GNT);
            fails++;
        end
        OUT_ACK = 1'b1;
        tick();
        OUT_ACK = 1'b0;
        tests++;
        if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || OUT !== 8'h30) begin
            $display("FAIL single_ack: got vld=%b busy=%b out=%h want 0/0/30", OUT_VALID, BUSY, OUT);
            fails++;
        end
    endtask

    task automatic test_opcodes();
        logic [7:0] expv [4];
        expv[0] = 8'h05;
        expv[1] = 8'hAF;
        expv[2] = 8'hAA;
        expv[3] = 8'h5A;
        X_IN = 32'h00_00_00_A5;
        Y_IN = 32'h00_00_00_0F;
        for (int i = 0; i < 4; i++) begin
            OP  = {6'b0, 2'(i)};
            REQ = 4'b0001;
            tick();
            REQ = 4'b0000;
            tick();
            tests++;
            if (OUT !== expv[i] || OUT_ID !== 3'd0 || OUT_VALID !== 1'b1) begin
                $display("FAIL opcode_%0d: got out=%h id=%0d vld=%b want %h/0/1", i, OUT, OUT_ID, OUT_VALID, expv[i]);
                fails++;
            end
            OUT_ACK = 1'b1;
            tick();
            OUT_ACK = 1'b0;
        end
    endtask

    task automatic test_round_robin();
        int g = 0;
        int v = 0;
        int last = 0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        OP   = 8'b01_10_00_01;
        X_IN = 32'h44_33_22_11;
        Y_IN = 32'h0F_0F_0F_0F;
        REQ  = 4'b1111;
        OUT_ACK = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            tick();
            if (GNT !== 4'b0000) begin
                tests++;
                if (GNT !== (4'b0001 << (g % 4)) || (g > 0 && cyc - last != 3)) begin
                    $display("FAIL rr_grant_%0d: got gnt=%b gap=%0d want %b gap 3", g, GNT, cyc - last, 4'b0001 << (g % 4));
                    fails++;
                end
                last = cyc;
                g++;
            end
            if (OUT_VALID === 1'b1) begin
                tests++;
                if (OUT_ID !== 3'(v % 4)) begin
                    $display("FAIL rr_id_%0d: got id=%0d want %0d", v, OUT_ID, v % 4);
                    fails++;
                end
                v++;
            end
        end
        REQ = 4'b0000;
        OUT_ACK = 1'b0;
        tests++;
        if (g != 5 || v != 5) begin
            $display("FAIL rr_count: got grants=%0d results=%0d want 5/5", g, v);
            fails++;
        end
    endtask

    task automatic test_backpressure();
        int wait_cnt = 0;
        OP   = 8'b00_00_00_00;
        X_IN = 32'h00_00_3C_00;
        Y_IN = 32'h00_00_FF_00;
        REQ  = 4'b0010;
        tick();
        tests++;
        if (GNT !== 4'b0010) begin
            $display("FAIL bp_first_gnt: got %b want 0010", GNT);
            fails++;
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (OUT !== 8'h3C || OUT_VALID !== 1'b1 || GNT !== 4'b0000 || OUT_ID !== 3'd1) begin
                $display("FAIL bp_hold_%0d: got out=%h vld=%b gnt=%b id=%0d want 3c/1/0000/1", i, OUT, OUT_VALID, GNT, OUT_ID);
                fails++;
            end
        end
        OUT_ACK = 1'b1;
        tick();
        OUT_ACK = 1'b0;
        while (GNT === 4'b0000 && wait_cnt < 2) begin
            tick();
            wait_cnt++;
        end
        REQ = 4'b0000;
        tests++;
        if (GNT !== 4'b0010) begin
            $display("FAIL bp_regrant: got gnt=%b after %0d cycles want 0010 within 2", GNT, wait_cnt);
            fails++;
        end
        tick();
        OUT_ACK = 1'b1;
        tick();
        OUT_ACK = 1'b0;
    endtask

    task automatic test_operand_change();
        OP   = 8'b01_00_00_00;
        X_IN = 32'hFF_00_00_00;
        Y_IN = 32'h00_00_00_00;
        REQ  = 4'b1000;
        tick();
        REQ  = 4'b0000;
        X_IN = 32'h00_00_00_00;
        tick();
        tests++;
        if (OUT !== 8'hFF || OUT_ID !== 3'd3 || OUT_VALID !== 1'b1) begin
            $display("FAIL operand_change: got out=%h id=%0d vld=%b want ff/3/1", OUT, OUT_ID, OUT_VALID);
            fails++;
        end
        OUT_ACK = 1'b1;
        tick();
        tick();
        OUT_ACK = 1'b0;
        tests++;
        if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || OUT !== 8'hFF || GNT !== 4'b0000) begin
            $display("FAIL idle_ack: got vld=%b busy=%b out=%h gnt=%b want 0/0/ff/0000", OUT_VALID, BUSY, OUT, GNT);
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        OP   = 8'b00_01_01_00;
        X_IN = 32'h00_0C_81_00;
        Y_IN = 32'h00_00_00_00;
        REQ  = 4'b0010;
        tick();
        REQ = 4'b0000;
        tick();
        OUT_ACK = 1'b1;
        tick();
        OUT_ACK = 1'b0;
        REQ = 4'b0100;
        tick();
        REQ = 4'b0000;
        tests++;
        if (GNT !== 4'b0100 || OUT !== 8'h81) begin
            $display("FAIL rst_setup: got gnt=%b out=%h want 0100/81", GNT, OUT);
            fails++;
        end
        #1;
        RST = 1'b1;
        #1;
        tests++;
        if (GNT !== 4'b0000 || OUT_VALID !== 1'b0 || OUT !== 8'h00 || BUSY !== 1'b0 || OUT_ID !== 3'd0) begin
            $display("FAIL rst_async: got gnt=%b vld=%b out=%h busy=%b id=%0d want all zero", GNT, OUT_VALID, OUT, BUSY, OUT_ID);
            fails++;
        end
        tick();
        RST = 1'b0;
        tests++;
        if (GNT !== 4'b0000 || OUT_VALID !== 1'b0) begin
            $display("FAIL rst_no_glitch: got gnt=%b vld=%b want 0000/0", GNT, OUT_VALID);
            fails++;
        end
        OP   = 8'b00_00_00_10;
        X_IN = 32'h77_00_00_3C;
        Y_IN = 32'h00_00_00_0F;
        REQ  = 4'b1001;
        tick();
        REQ = 4'b0000;
        tests++;
        if (GNT !== 4'b0001) begin
            $display("FAIL rst_first_gnt: got %b want 0001", GNT);
            fails++;
        end
        tick();
        tests++;
        if (OUT !== 8'h33 || OUT_ID !== 3'd0 || OUT_VALID !== 1'b1) begin
            $display("FAIL rst_result: got out=%h id=%0d vld=%b want 33/0/1", OUT, OUT_ID, OUT_VALID);
            fails++;
        end
        OUT_ACK = 1'b1;
        tick();
        OUT_ACK = 1'b0;
    endtask

    initial begin
        RST     = 1'b1;
        REQ     = 4'b0000;
        OP      = 8'h00;
        X_IN    = 32'h0;
        Y_IN    = 32'h0;
        OUT_ACK = 1'b0;
        test_reset();
        test_single();
        test_opcodes();
        test_round_robin();
        test_backpressure();
        test_operand_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
